id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for a five-stage RISC-V style core.
// Carries decode-stage control, operands and register addresses into execute.
// Priority per clock edge: rst > flush_e > stall_e > load.
// The optional bubble counter is compiled in only when ID_EX_PERF_CNT_EN is defined.
module id_ex_reg #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic [9:0]       ctrl_d,
    input  logic [31:0]      rd1_d,
    input  logic [31:0]      rd2_d,
    input  logic [31:0]      imm_ext_d,
    input  logic [31:0]      pc_d,
    input  logic [31:0]      pcplus4_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    output logic             valid_e,
    output logic [9:0]       ctrl_e,
    output logic [31:0]      rd1_e,
    output logic [31:0]      rd2_e,
    output logic [31:0]      imm_ext_e,
    output logic [31:0]      pc_e,
    output logic [31:0]      pcplus4_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
`ifdef ID_EX_PERF_CNT_EN
    output logic [4:0]       rd_e,
    output logic [CNT_W-1:0] bubble_cnt
`else
    output logic [4:0]       rd_e
`endif
);

    // Execute-slot occupancy: BUBBLE means the slot holds no real instruction.
    typedef enum logic {
        BUBBLE = 1'b0,
        VALID  = 1'b1
    } slot_state_t;

    slot_state_t state_q;

    logic [9:0]  ex_ctrl_d,    ex_ctrl_q;
    logic [31:0] ex_rd1_d,     ex_rd1_q;
    logic [31:0] ex_rd2_d,     ex_rd2_q;
    logic [31:0] ex_imm_d,     ex_imm_q;
    logic [31:0] ex_pc_d,      ex_pc_q;
    logic [31:0] ex_pcplus4_d, ex_pcplus4_q;
    logic [4:0]  ex_rs1_d,     ex_rs1_q;
    logic [4:0]  ex_rs2_d,     ex_rs2_q;
    logic [4:0]  ex_rd_d,      ex_rd_q;

    logic load;
    assign load = !flush_e && !stall_e;

    // Next-state selection for the payload: flush clears, stall holds, load captures.
    // An invalid slot still carries its data but never any control bits.
    always_comb begin
        ex_ctrl_d    = ex_ctrl_q;
        ex_rd1_d     = ex_rd1_q;
        ex_rd2_d     = ex_rd2_q;
        ex_imm_d     = ex_imm_q;
        ex_pc_d      = ex_pc_q;
        ex_pcplus4_d = ex_pcplus4_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        if (flush_e) begin
            ex_ctrl_d    = '0;
            ex_rd1_d     = '0;
            ex_rd2_d     = '0;
            ex_imm_d     = '0;
            ex_pc_d      = '0;
            ex_pcplus4_d = '0;
            ex_rs1_d     = '0;
            ex_rs2_d     = '0;
            ex_rd_d      = '0;
        end else if (load) begin
            ex_ctrl_d    = valid_d ? ctrl_d : 10'd0;
            ex_rd1_d     = rd1_d;
            ex_rd2_d     = rd2_d;
            ex_imm_d     = imm_ext_d;
            ex_pc_d      = pc_d;
            ex_pcplus4_d = pcplus4_d;
            ex_rs1_d     = rs1_d;
            ex_rs2_d     = rs2_d;
            ex_rd_d      = rd_d;
        end
    end

    // Payload registers; reset clears them so nothing stale survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q    <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_pcplus4_q <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rd1_q     <= ex_rd1_d;
            ex_rd2_q     <= ex_rd2_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            ex_pcplus4_q <= ex_pcplus4_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
        end
    end

    // Slot occupancy FSM: only a valid load fills the slot; flush or invalid load empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUBBLE;
        end else if (flush_e) begin
            state_q <= BUBBLE;
        end else if (!stall_e) begin
            case (state_q)
                BUBBLE:  state_q <= valid_d ? VALID : BUBBLE;
                VALID:   state_q <= valid_d ? VALID : BUBBLE;
                default: state_q <= BUBBLE;
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             bubble_edge;

    // A bubble is produced by a flush or by loading an invalid slot; stalls do not count.
    assign bubble_edge = flush_e || (load && !valid_d);

    // Saturating increment so a long-running counter never wraps back to small values.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_edge && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

    assign valid_e   = (state_q == VALID);
    assign ctrl_e    = ex_ctrl_q;
    assign rd1_e     = ex_rd1_q;
    assign rd2_e     = ex_rd2_q;
    assign imm_ext_e = ex_imm_q;
    assign pc_e      = ex_pc_q;
    assign pcplus4_e = ex_pcplus4_q;
    assign rs1_e     = ex_rs1_q;
    assign rs2_e     = ex_rs2_q;
    assign rd_e      = ex_rd_q;

endmodule
